// File: rtl/plic_pkg.sv
// plic_pkg: shared PLIC address map, claim agent states and ID width.
// Used by both the interrupt controller and the claim agent.
package plic_pkg;

  localparam int ID_W = 32;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CLAIM    = 3'd2,
    ST_PRESENT  = 3'd3,
    ST_SERVICE  = 3'd4,
    ST_COMPLETE = 3'd5
  } plic_state_e;

  // Number of 32-bit words needed to hold one bit per source.
  function automatic logic [31:0] src_words(
    input logic [31:0] n
  );
    return (n + 32'd31) >> 5;
  endfunction

  // Priority threshold register: skips the priority array
  // and the pending/enable bitmaps.
  function automatic logic [31:0] thr_addr(
    input logic [31:0] base,
    input logic [31:0] n
  );
    return base + 32'd4 + (n << 2)
         + (src_words(n) << 3) + 32'd4;
  endfunction

  // Claim/complete register follows the threshold.
  function automatic logic [31:0] cc_addr(
    input logic [31:0] base,
    input logic [31:0] n
  );
    return thr_addr(base, n) + 32'd4;
  endfunction

endpackage

// File: rtl/plic_spurious_counter.sv
// plic_spurious_counter: 8-bit saturating event counter.
// Counts up on inc, sticks at 255.
module plic_spurious_counter
  import plic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  // Saturating increment; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/plic_claim_agent.sv
// plic_claim_agent: claims PLIC interrupts, hands IDs to the core
// and writes completion back once the core has serviced them.
module plic_claim_agent
  import plic_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h8004_0000,
  parameter logic [31:0] N_INTERRUPTS    = 32'd32,
  parameter logic [31:0] THRESHOLD_VALUE = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interrupt_service_request,
  output logic [31:0]     addr,
  output logic            ren,
  output logic            wen,
  output logic [31:0]     wdata,
  input  logic [31:0]     rdata,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ready,
  input  logic            irq_done,
  output logic [7:0]      spurious_count,
  output logic            busy
);

  localparam logic [31:0] THR_ADDR =
    thr_addr(BASE_ADDRESS, N_INTERRUPTS);
  localparam logic [31:0] CC_ADDR =
    cc_addr(BASE_ADDRESS, N_INTERRUPTS);

  plic_state_e     state_q;
  plic_state_e     state_d;
  logic            pending_q;
  logic            pending_clr;
  logic [ID_W-1:0] id_q;
  logic            spur_inc;

  // State, pending flag and claimed ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      pending_q <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q <= state_d;
      // A new pulse wins over the clear in the same cycle.
      if (interrupt_service_request) begin
        pending_q <= 1'b1;
      end else if (pending_clr) begin
        pending_q <= 1'b0;
      end
      if (state_q == ST_CLAIM) begin
        id_q <= rdata;
      end
    end
  end

  // Next-state logic; only state transitions look at inputs.
  always_comb begin
    state_d     = state_q;
    pending_clr = 1'b0;
    spur_inc    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pending_q) begin
          pending_clr = 1'b1;
          state_d     = ST_CLAIM;
        end
      end
      ST_CLAIM: begin
        if (rdata == '0) begin
          spur_inc = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (irq_ready) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (irq_done) begin
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Bus and core outputs decoded from state; reset masks the
  // INIT write so nothing reaches the bus while rst is high.
  always_comb begin
    addr      = '0;
    ren       = 1'b0;
    wen       = 1'b0;
    wdata     = '0;
    irq_valid = 1'b0;
    irq_id    = '0;
    busy      = (state_q != ST_IDLE);
    if (!rst) begin
      unique case (state_q)
        ST_INIT: begin
          wen   = 1'b1;
          addr  = THR_ADDR;
          wdata = THRESHOLD_VALUE;
        end
        ST_CLAIM: begin
          ren  = 1'b1;
          addr = CC_ADDR;
        end
        ST_PRESENT: begin
          irq_valid = 1'b1;
          irq_id    = id_q;
        end
        ST_COMPLETE: begin
          wen   = 1'b1;
          addr  = CC_ADDR;
          wdata = id_q;
        end
        default: begin
        end
      endcase
    end
  end

  plic_spurious_counter u_spur (
    .clk   (clk),
    .rst   (rst),
    .inc   (spur_inc),
    .count (spurious_count)
  );

endmodule
